// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: assembles PS/2 Set-2 scancode bytes into toggle-marked ps2_key events
module ps2_key_encoder #(
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [10:0] ps2_key,
  output logic        drop
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] TMO = W'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP, PAUSE_REL} state_t;
  state_t state, state_nxt;
  logic [2:0] skip, skip_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic emit, drp, acc, ctrl, fake;
  logic [9:0] ev;
  assign byte_ready = state != PAUSE_REL;
  assign acc = byte_valid && byte_ready;
  assign ctrl = byte_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  assign fake = byte_data inside {8'h12, 8'h59};
  always_comb begin
    state_nxt = state;
    skip_nxt = skip;
    emit = 1'b0;
    drp = 1'b0;
    ev = ps2_key[9:0];
    if (state == PAUSE_REL) begin
      emit = 1'b1;
      ev = {2'b01, 8'h77};
      state_nxt = IDLE;
    end else if (acc && state == SKIP) begin
      // pause body bytes are counted blindly, control values included
      skip_nxt = skip - 3'd1;
      if (skip == 3'd1) begin
        emit = 1'b1;
        ev = {2'b11, 8'h77};
        state_nxt = PAUSE_REL;
      end
    end else if (acc && ctrl) begin
      drp = 1'b1;
      state_nxt = IDLE;
    end else if (acc) begin
      case (state)
        IDLE:
          if (byte_data == 8'hE0) state_nxt = EXT;
          else if (byte_data == 8'hF0) state_nxt = BRK;
          else if (byte_data == 8'hE1) begin
            state_nxt = SKIP;
            skip_nxt = 3'd7;
          end else begin
            emit = 1'b1;
            ev = {2'b10, byte_data};
          end
        EXT:
          if (byte_data == 8'hF0) state_nxt = EXTBRK;
          else begin
            state_nxt = IDLE;
            drp = fake;
            emit = !fake;
            ev = {2'b11, byte_data};
          end
        BRK: begin
          state_nxt = IDLE;
          emit = 1'b1;
          ev = {2'b00, byte_data};
        end
        EXTBRK: begin
          state_nxt = IDLE;
          drp = fake;
          emit = !fake;
          ev = {2'b01, byte_data};
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && cnt == TMO) begin
      drp = 1'b1;
      state_nxt = IDLE;
    end
    cnt_nxt = (acc || state_nxt == IDLE || state_nxt == PAUSE_REL) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      skip <= '0;
      cnt <= '0;
      ps2_key <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nxt;
      skip <= skip_nxt;
      cnt <= cnt_nxt;
      drop <= drp;
      if (emit) ps2_key <= {~ps2_key[10], ev};
    end
  end
endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed scenario bench for ps2_key_encoder
module tb_ps2_key_encoder;
  logic clk = 1'b0, reset = 1'b1, byte_valid = 1'b0, byte_ready, drop;
  logic [7:0] byte_data = 8'h00;
  logic [10:0] ps2_key;
  logic exp_t = 1'b0;
  int tests = 0, fails = 0, drops = 0;

  ps2_key_encoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .ps2_key(ps2_key), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (drop) drops++;

  task automatic send(input logic [7:0] b);
    logic r, ok;
    ok = 1'b0;
    byte_data = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 4 && !ok; n++) begin
      r = byte_ready;
      @(posedge clk);
      @(negedge clk);
      ok = r;
    end
    byte_valid = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL send_%h: accepted=%b required=1", b, ok); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests += 3;
    if (ps2_key !== 11'h000) begin fails++; $display("FAIL reset_key: got %h want 000", ps2_key); end
    if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b want 0", drop); end
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", byte_ready); end
    reset = 1'b0;
  endtask

  task automatic test_make_break;
    send(8'h1C);
    exp_t = ~exp_t;
    tests += 2;
    if (ps2_key !== {exp_t, 10'h21C}) begin fails++; $display("FAIL make_1c: got %h want %h", ps2_key, {exp_t, 10'h21C}); end
    if (drop !== 1'b0) begin fails++; $display("FAIL make_drop: got %b want 0", drop); end
    send(8'hF0);
    tests++;
    if (ps2_key !== {exp_t, 10'h21C}) begin fails++; $display("FAIL f0_noevent: got %h want %h", ps2_key, {exp_t, 10'h21C}); end
    send(8'h1C);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h01C}) begin fails++; $display("FAIL break_1c: got %h want %h", ps2_key, {exp_t, 10'h01C}); end
  endtask

  task automatic test_extended;
    send(8'hE0);
    send(8'h75);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h375}) begin fails++; $display("FAIL ext_make: got %h want %h", ps2_key, {exp_t, 10'h375}); end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h175}) begin fails++; $display("FAIL ext_break: got %h want %h", ps2_key, {exp_t, 10'h175}); end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      tests++;
      if (ps2_key[10] !== exp_t) begin fails++; $display("FAIL pause_body_%0d: toggle %b want %b", i, ps2_key[10], exp_t); end
    end
    send(seq[7]);
    exp_t = ~exp_t;
    tests += 2;
    if (ps2_key !== {exp_t, 10'h377}) begin fails++; $display("FAIL pause_press: got %h want %h", ps2_key, {exp_t, 10'h377}); end
    if (byte_ready !== 1'b0) begin fails++; $display("FAIL pause_ready_low: got %b want 0", byte_ready); end
    @(negedge clk);
    exp_t = ~exp_t;
    tests += 2;
    if (ps2_key !== {exp_t, 10'h177}) begin fails++; $display("FAIL pause_release: got %h want %h", ps2_key, {exp_t, 10'h177}); end
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL pause_ready_back: got %b want 1", byte_ready); end
  endtask

  task automatic test_control;
    int d0;
    d0 = drops;
    send(8'hFA);
    tests++;
    if (drop !== 1'b1) begin fails++; $display("FAIL ctrl_fa_drop: got %b want 1", drop); end
    send(8'hAA);
    send(8'hE0);
    send(8'h12);
    tests++;
    if (drop !== 1'b1) begin fails++; $display("FAIL fake_12_drop: got %b want 1", drop); end
    send(8'hE0);
    send(8'hF0);
    send(8'h59);
    @(negedge clk);
    tests += 2;
    if (drops - d0 !== 4) begin fails++; $display("FAIL ctrl_drop_count: got %0d want 4", drops - d0); end
    if (ps2_key[10] !== exp_t) begin fails++; $display("FAIL ctrl_no_toggle: got %b want %b", ps2_key[10], exp_t); end
    send(8'h29);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h229}) begin fails++; $display("FAIL after_ctrl_29: got %h want %h", ps2_key, {exp_t, 10'h229}); end
  endtask

  task automatic test_timeout;
    send(8'hE0);
    repeat (16) @(negedge clk);
    tests++;
    if (drop !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", drop); end
    @(negedge clk);
    tests += 2;
    if (drop !== 1'b1) begin fails++; $display("FAIL timeout_drop: got %b want 1", drop); end
    if (ps2_key[10] !== exp_t) begin fails++; $display("FAIL timeout_no_event: got %b want %b", ps2_key[10], exp_t); end
    send(8'h75);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h275}) begin fails++; $display("FAIL timeout_then_75: got %h want %h", ps2_key, {exp_t, 10'h275}); end
    send(8'hE0);
    repeat (14) @(negedge clk);
    send(8'h75);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h375}) begin fails++; $display("FAIL no_timeout_15: got %h want %h", ps2_key, {exp_t, 10'h375}); end
  endtask

  task automatic test_async_reset;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq[i]);
    #2 reset = 1'b1;
    #1;
    tests += 2;
    if (ps2_key !== 11'h000) begin fails++; $display("FAIL rst_pause_key: got %h want 000", ps2_key); end
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL rst_pause_ready: got %b want 1", byte_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (ps2_key !== 11'h000) begin fails++; $display("FAIL rst_pause_no_release: got %h want 000", ps2_key); end
    exp_t = 1'b0;
    send(8'hF0);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (ps2_key !== 11'h000) begin fails++; $display("FAIL rst_async_key: got %h want 000", ps2_key); end
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C);
    exp_t = ~exp_t;
    tests++;
    if (ps2_key !== {exp_t, 10'h21C}) begin fails++; $display("FAIL rst_then_make: got %h want %h", ps2_key, {exp_t, 10'h21C}); end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_extended;
    test_pause;
    test_control;
    test_timeout;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
